uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte-wide transmit FIFO and handshake controller that sits directly upstream of the UART transmitter. It accepts bytes from the CPU/IO bus at full clock rate and buffers them. It drains them one at a time into the transmitter's DV/byte/done handshake, so software never stalls on the serial rate.

## Interface

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- ADDR_W, 4, log2(DEPTH)

Ports:
- i_Clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- i_wr_en  in  1  write strobe; one byte per cycle
- i_wr_data  in  8  byte to enqueue
- o_full  out  1  FIFO holds DEPTH entries
- o_empty  out  1  FIFO holds 0 entries
- o_busy  out  1  FIFO non-empty OR handshake state ≠ IDLE
- o_Tx_DV  out  1  to transmitter i_Tx_DV
- o_Tx_Byte  out  8  to transmitter i_Tx_Byte; registered
- i_Tx_Done  in  1  from transmitter o_Tx_Done
- i_Tx_Active  in  1  from transmitter o_Tx_Active

## Operation

- Storage: DEPTH×8 register array, wr_ptr/rd_ptr of ADDR_W+1 bits (wrap bit).
  - empty = pointers equal.
  - full = low ADDR_W bits equal, MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
- Write: on edge with i_wr_en=1 and o_full=0, mem[wr_ptr]←i_wr_data, wr_ptr+1.
  - i_wr_en=1 while o_full=1: byte dropped, no state change.
  - Full is judged on pre-edge state, even if a pop occurs the same edge.
- Controller FSM, 2 bits: IDLE, REQ, RELEASE.
  - IDLE: if !empty && !i_Tx_Done && !i_Tx_Active:
    - o_Tx_Byte←mem[rd_ptr], rd_ptr+1, o_Tx_DV←1, go REQ.
    - Otherwise stay.
  - REQ: hold o_Tx_DV=1 and o_Tx_Byte stable. When i_Tx_Done=1: o_Tx_DV←0, go RELEASE.
  - RELEASE: o_Tx_DV=0. When i_Tx_Done=0, go IDLE.
  - Illegal encoding → IDLE, o_Tx_DV←0.
- The IDLE gate on i_Tx_Done/i_Tx_Active ensures DV is never raised while the transmitter is mid-frame or in cleanup. This includes the case where reset hits this block but not the transmitter.
- Simultaneous write and pop in the same edge are both performed; the pointers are independent.
- Reset values:
  - o_Tx_DV=0, o_Tx_Byte=8'h00, o_empty=1, o_full=0, o_busy=0.
  - FSM=IDLE, both pointers 0. Array contents are not reset.
- Reset mid-operation: queued bytes are discarded and DV drops asynchronously. A frame already in the transmitter completes on its own.

## Timing

- o_full/o_empty/o_busy are combinational from registered state only.
- Write to empty FIFO sampled at edge N: o_empty=0 after N; o_Tx_DV=1 and o_Tx_Byte valid after N+1. This assumes the transmitter is idle.
- REQ→RELEASE: one edge after i_Tx_Done is seen high.
- RELEASE→IDLE: one edge after i_Tx_Done is seen low.
- Next pop: the IDLE edge after that, giving at least 3 cycles between frames beyond transmitter overhead.
- Throughput: one byte per transmitter frame. Writes are never back-pressured except by o_full.

## Configuration

- UART_TX_FIFO_STATUS_EN defined adds three ports:
  - o_level out ADDR_W+1: wr_ptr−rd_ptr, range 0..DEPTH.
  - o_overflow out 1: sticky; set on a dropped write; reset value 0.
  - i_clr_overflow in 1: synchronous clear. If a dropped write occurs in the same cycle, set wins.
- Not defined: these ports and their logic are absent. Dropped writes are silent.

## Test plan

- Single byte: write 8'hA5 to idle FIFO with real transmitter model (50 clk/bit) → DV high 2 edges after write; serial line shows start bit, A5 LSB-first, stop bit; o_busy low after Done clears.
- Burst: write 8'h01..8'h10 back-to-back (DEPTH=16) → o_full=1 after 16th; all 16 bytes transmitted in order; o_empty=1 at end.
- Overflow: fill 16, write 8'hFF while full → byte not transmitted; with STATUS_EN, o_overflow=1 and o_level=16; i_clr_overflow → 0.
- Write-while-pop: FIFO full, pop edge coincides with i_wr_en → write dropped, level becomes 15.
- Handshake stall: hold i_Tx_Done=0 in REQ for 1000 cycles → DV and byte stay stable; raise Done → DV low next edge.
- Reset mid-frame: assert reset low while transmitter is sending byte 2 of 4 → DV=0 immediately, FIFO empty; after release, write 8'h55 → DV waits until i_Tx_Active=0 and i_Tx_Done=0, then 55 is sent intact.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding a UART transmitter through its DV/byte/done handshake.
// Define UART_TX_FIFO_STATUS_EN to add the o_level / o_overflow / i_clr_overflow status ports.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         i_Clock,
  input  logic         reset,
  input  logic         i_wr_en,
  input  logic [7:0]   i_wr_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_busy,
  output logic         o_Tx_DV,
  output logic [7:0]   o_Tx_Byte,
`ifdef UART_TX_FIFO_STATUS_EN
  output logic [ADDR_W:0] o_level,
  output logic         o_overflow,
  input  logic         i_clr_overflow,
`endif
  input  logic         i_Tx_Done,
  input  logic         i_Tx_Active
);

  // state   | meaning
  // IDLE    | waiting for a queued byte and a quiet transmitter
  // REQ     | DV raised, byte held until the transmitter reports done
  // RELEASE | DV dropped, waiting for done to fall before the next pop
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  state_t          state;
  logic            wr_fire;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign o_busy  = !o_empty || (state != IDLE);
  assign wr_fire = i_wr_en && !o_full;

  always_ff @(posedge i_Clock) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Pop only when the transmitter is neither mid-frame nor still signalling done,
  // which also covers this block being reset while the transmitter was not.
  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!o_empty && !i_Tx_Done && !i_Tx_Active) begin
            o_Tx_Byte <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr    <= rd_ptr + PTR_ONE;
            o_Tx_DV   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (i_Tx_Done) begin
            o_Tx_DV <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          o_Tx_DV <= 1'b0;
          if (!i_Tx_Done) begin
            state <= IDLE;
          end
        end
        default: begin
          o_Tx_DV <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign o_level = wr_ptr - rd_ptr;

  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      o_overflow <= 1'b0;
    end else if (i_wr_en && o_full) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-level reference model checked every cycle, a serial
// transmitter model on the handshake, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int CPB = 50;
  localparam int WAITING = 0, OFFERED = 1, RELEASING = 2;

  logic i_Clock = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic tx_done = 1'b0;
  logic tx_active = 1'b0;
  logic o_full, o_empty, o_busy, o_Tx_DV;
  logic [7:0] o_Tx_Byte;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [ADDR_W:0] o_level;
  logic o_overflow;
  logic clr_ovf = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock(i_Clock),
    .reset(reset),
    .i_wr_en(wr_en),
    .i_wr_data(wr_data),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_busy(o_busy),
    .o_Tx_DV(o_Tx_DV),
    .o_Tx_Byte(o_Tx_Byte),
`ifdef UART_TX_FIFO_STATUS_EN
    .o_level(o_level),
    .o_overflow(o_overflow),
    .i_clr_overflow(clr_ovf),
`endif
    .i_Tx_Done(tx_done),
    .i_Tx_Active(tx_active)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a byte queue; the handshake is tracked as
  // waiting / offered / releasing from the transmitter's point of view.
  logic [7:0] q[$];
  int phase = WAITING;
  logic m_dv = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic m_ovf = 1'b0;
  bit was_full;

  always @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      phase = WAITING;
      m_dv = 1'b0;
      m_byte = 8'h00;
      m_ovf = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      case (phase)
        WAITING: if (q.size() > 0 && !tx_done && !tx_active) begin
          m_byte = q.pop_front();
          m_dv = 1'b1;
          phase = OFFERED;
        end
        OFFERED: if (tx_done) begin
          m_dv = 1'b0;
          phase = RELEASING;
        end
        default: if (!tx_done) phase = WAITING;
      endcase
      if (wr_en && !was_full) q.push_back(wr_data);
`ifdef UART_TX_FIFO_STATUS_EN
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
`endif
    end
  end

  always @(negedge i_Clock) begin
    check("cycle_outputs", {o_Tx_DV, o_Tx_Byte, o_full, o_empty, o_busy},
          {m_dv, m_byte, q.size() == DEPTH, q.size() == 0, (q.size() != 0) || (phase != WAITING)});
`ifdef UART_TX_FIFO_STATUS_EN
    check("cycle_status", {o_overflow, o_level}, {m_ovf, q.size()[ADDR_W:0]});
`endif
  end

  // Transmitter model: 8N1 frame at CPB clocks/bit, one-cycle done pulse after stop bit.
  bit tx_auto = 1'b1;
  int tx_state = 0;
  int cnt = 0;
  int bitidx = 0;
  logic [7:0] shreg;
  logic [9:0] frame;
  logic serial = 1'b1;
  logic [7:0] sent_q[$];

  always @(negedge i_Clock) begin
    if (tx_auto) begin
      case (tx_state)
        0: begin
          tx_done = 1'b0;
          if (o_Tx_DV) begin
            shreg = o_Tx_Byte;
            tx_active = 1'b1;
            cnt = 0;
            bitidx = 0;
            tx_state = 1;
          end
        end
        1: begin
          serial = (bitidx == 0) ? 1'b0 : (bitidx <= 8) ? shreg[bitidx-1] : 1'b1;
          if (cnt == CPB / 2) frame[bitidx] = serial;
          cnt++;
          if (cnt == CPB) begin
            cnt = 0;
            bitidx++;
            if (bitidx == 10) begin
              tx_active = 1'b0;
              tx_done = 1'b1;
              tx_state = 2;
              check("frame_start_stop", {frame[9], frame[0]}, 2'b10);
              sent_q.push_back(frame[8:1]);
            end
          end
        end
        default: begin
          tx_done = 1'b0;
          tx_state = 0;
        end
      endcase
    end
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge i_Clock);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge i_Clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget, input string name);
    int k = 0;
    while (sent_q.size() < n && k < budget) begin
      @(negedge i_Clock);
      k++;
    end
    check(name, sent_q.size(), n);
  endtask

  task automatic hold_transmitter_busy();
    @(negedge i_Clock);
    tx_auto = 1'b0;
    tx_active = 1'b1;
    tx_done = 1'b0;
  endtask

  initial begin
    bit stable;
    int k;
    repeat (3) @(negedge i_Clock);
    check("reset_dv", o_Tx_DV, 0);
    check("reset_byte", o_Tx_Byte, 8'h00);
    check("reset_flags", {o_empty, o_full, o_busy}, 3'b100);
    reset = 1'b1;

    // Single byte to an idle FIFO
    @(negedge i_Clock);
    sent_q.delete();
    wr_en = 1'b1;
    wr_data = 8'hA5;
    @(negedge i_Clock);
    wr_en = 1'b0;
    check("single_empty_after_write", {o_empty, o_Tx_DV}, 2'b00);
    @(negedge i_Clock);
    check("single_dv_second_edge", {o_Tx_DV, o_Tx_Byte}, {1'b1, 8'hA5});
    wait_sent(1, 700, "single_sent_timeout");
    check("single_byte_serial", sent_q[0], 8'hA5);
    repeat (3) @(negedge i_Clock);
    check("single_busy_low", {o_busy, o_empty}, 2'b01);

    // Burst of 16 while the transmitter is busy, then one dropped write
    hold_transmitter_busy();
    sent_q.delete();
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    check("burst_full", {o_full, o_empty}, 2'b10);
    write_byte(8'hFF);
    check("overflow_still_full", o_full, 1);
`ifdef UART_TX_FIFO_STATUS_EN
    check("overflow_flag", {o_overflow, o_level}, {1'b1, 5'd16});
    @(negedge i_Clock);
    clr_ovf = 1'b1;
    @(negedge i_Clock);
    clr_ovf = 1'b0;
    check("overflow_cleared", o_overflow, 0);
`endif
    tx_active = 1'b0;
    tx_state = 0;
    tx_auto = 1'b1;
    wait_sent(16, 16 * 700, "burst_sent_timeout");
    repeat (700) @(negedge i_Clock);
    check("burst_no_extra", sent_q.size(), 16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++) check("burst_order", sent_q[i], 8'(i + 1));
    check("burst_empty_end", {o_empty, o_busy}, 2'b10);

    // Write coinciding with the first pop from a full FIFO is dropped
    hold_transmitter_busy();
    sent_q.delete();
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    @(negedge i_Clock);
    tx_active = 1'b0;
    tx_state = 0;
    tx_auto = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge i_Clock);
    wr_en = 1'b0;
    check("wwp_not_full", {o_full, o_empty, o_Tx_DV}, 3'b001);
`ifdef UART_TX_FIFO_STATUS_EN
    check("wwp_level", o_level, 5'd15);
`endif
    wait_sent(16, 16 * 700, "wwp_sent_timeout");
    repeat (700) @(negedge i_Clock);
    check("wwp_no_extra", sent_q.size(), 16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++) check("wwp_order", sent_q[i], 8'h20 + 8'(i));

    // Handshake stall: done withheld for 1000 cycles
    @(negedge i_Clock);
    tx_auto = 1'b0;
    tx_active = 1'b0;
    tx_done = 1'b0;
    write_byte(8'h3C);
    @(negedge i_Clock);
    check("stall_dv_up", {o_Tx_DV, o_Tx_Byte}, {1'b1, 8'h3C});
    stable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clock);
      if (o_Tx_DV !== 1'b1 || o_Tx_Byte !== 8'h3C) stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    tx_done = 1'b1;
    @(negedge i_Clock);
    check("stall_dv_drop", {o_Tx_DV, o_busy}, 2'b01);
    tx_done = 1'b0;
    @(negedge i_Clock);
    @(negedge i_Clock);
    check("stall_idle", o_busy, 0);

    // Reset while the transmitter is sending byte 2 of 4
    tx_state = 0;
    tx_auto = 1'b1;
    sent_q.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    k = 0;
    while (!(tx_state == 1 && bitidx == 4 && sent_q.size() == 1) && k < 2000) begin
      @(negedge i_Clock);
      k++;
    end
    check("midframe_reach_timeout", k < 2000, 1);
    @(posedge i_Clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {o_Tx_DV, o_empty, o_busy}, 3'b010);
    repeat (3) @(negedge i_Clock);
    reset = 1'b1;
    write_byte(8'h55);
    @(negedge i_Clock);
    check("dv_held_while_active", {o_Tx_DV, o_empty}, 2'b00);
    wait_sent(3, 2000, "post_reset_timeout");
    if (sent_q.size() >= 3) begin
      check("post_reset_seq0", sent_q[0], 8'h11);
      check("post_reset_seq1", sent_q[1], 8'h22);
      check("post_reset_seq2", sent_q[2], 8'h55);
    end
    repeat (5) @(negedge i_Clock);
    check("post_reset_idle", {o_busy, o_empty}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
